// File: rtl/key_encoder.sv
// Four-button front end: synchronize, debounce and encode key presses into
// code/valid strobes with hold-to-repeat.

module key_debounce #(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic key_o
);
  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [1:0]    SYNC_RST = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_q, key_d;
  logic          lvl;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= SYNC_RST;
      cnt_q  <= '0;
      key_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_i};
      cnt_q  <= cnt_d;
      key_q  <= key_d;
    end
  end

  assign lvl = (ACTIVE_LOW != 0) ? ~sync_q[1] : sync_q[1];

  // Toggle on the first mismatching sample after DEBOUNCE_CYCLES mismatches.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    key_d = key_q;
    if (lvl == key_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      key_d = ~key_q;
    end
  end

  assign key_o = key_q;
endmodule

module key_encoder #(
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000,
  parameter int REPEAT_EN       = 1
) (
  input  logic       clkI,
  input  logic       rstnI,
  input  logic [3:0] keyI,
  output logic [3:0] keysO,
  output logic       anyO,
  output logic [1:0] codeO,
  output logic       validO,
  output logic       multiO
);
  localparam int NUM_KEYS = 4;
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_DELAY  = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0] T_PERIOD = TW'(REPEAT_PERIOD);
  localparam logic [TW-1:0] T_ONE    = TW'(1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_e;

  logic [NUM_KEYS-1:0] keys_w, prev_q, press;
  logic [1:0]          low_idx;
  logic                multi_now;

  state_e          state_q, state_d;
  logic [1:0]      trk_q, trk_d, code_q, code_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            valid_q, valid_d, multi_q, multi_d;

  genvar g;
  generate
    for (g = 0; g < NUM_KEYS; g++) begin : g_key
      key_debounce #(
        .ACTIVE_LOW     (KEY_ACTIVE_LOW),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk_i (clkI),
        .rst_ni(rstnI),
        .key_i (keyI[g]),
        .key_o (keys_w[g])
      );
    end
  endgenerate

  assign press     = keys_w & ~prev_q;
  assign multi_now = (keys_w & (keys_w - 1'b1)) != '0;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (press[i]) low_idx = 2'(i);
  end

  // A new press always wins over release of the tracked key and over expiry.
  always_comb begin
    state_d = state_q;
    trk_d   = trk_q;
    timer_d = timer_q;
    valid_d = 1'b0;
    code_d  = code_q;
    multi_d = multi_q;
    if (press != '0) begin
      valid_d = 1'b1;
      code_d  = low_idx;
      trk_d   = low_idx;
      multi_d = multi_now;
      timer_d = T_DELAY;
      state_d = HOLD;
    end else begin
      case (state_q)
        IDLE: ;
        HOLD, REPEAT: begin
          if (!keys_w[trk_q]) begin
            state_d = IDLE;
          end else if (timer_q == T_ONE && (state_q == REPEAT || REPEAT_EN != 0)) begin
            valid_d = 1'b1;
            code_d  = trk_q;
            multi_d = multi_now;
            timer_d = T_PERIOD;
            state_d = REPEAT;
          end else if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clkI or negedge rstnI) begin
    if (!rstnI) begin
      prev_q  <= '0;
      state_q <= IDLE;
      trk_q   <= '0;
      timer_q <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      multi_q <= 1'b0;
    end else begin
      prev_q  <= keys_w;
      state_q <= state_d;
      trk_q   <= trk_d;
      timer_q <= timer_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      multi_q <= multi_d;
    end
  end

  assign keysO  = keys_w;
  assign anyO   = |keys_w;
  assign codeO  = code_q;
  assign validO = valid_q;
  assign multiO = multi_q;
endmodule

// File: tb/tb_key_encoder.sv
// Bench for key_encoder: windowed-debounce / due-time event model checked every
// cycle, directed scenarios with literal event times, then random key traffic.

module tb_key_encoder;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk;
  logic       rstnI;
  logic [3:0] keyI, key0I;
  logic [3:0] keysO, keys0;
  logic       anyO, any0, validO, valid0, multiO, multi0;
  logic [1:0] codeO, code0;

  key_encoder #(.KEY_ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD),
                .REPEAT_PERIOD(RP), .REPEAT_EN(1)) dut (
    .clkI(clk), .rstnI(rstnI), .keyI(keyI), .keysO(keysO), .anyO(anyO),
    .codeO(codeO), .validO(validO), .multiO(multiO));

  key_encoder #(.KEY_ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD),
                .REPEAT_PERIOD(RP), .REPEAT_EN(0)) dut0 (
    .clkI(clk), .rstnI(rstnI), .keyI(key0I), .keysO(keys0), .anyO(any0),
    .codeO(code0), .validO(valid0), .multiO(multi0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  logic [3:0] s_key = 4'hF;
  logic       s_rst = 1'b0;
  int ev_cyc[$], ev_code[$], ev_multi[$];
  int n_v0 = 0;
  int c0, c1;

  // Model state: sample history, debounced keys, tracked key, next due step.
  bit [3:0] m_hist [0:D+2];
  bit [3:0] m_deb = '0, m_deb_old = '0;
  int       m_trk = -1;
  int       m_n = 0, m_due = 0;
  bit       m_val = 0, m_multi = 0;
  bit [1:0] m_code = '0;

  task automatic check_int(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_ev(input int idx, input int ecyc, input int ecode, input int emulti);
    if (idx >= ev_cyc.size()) begin
      n_chk++;
      n_fail++;
      $display("FAIL ev%0d: missing event, got %0d events, expected one at cyc %0d",
               idx, ev_cyc.size(), ecyc);
    end else begin
      check_int($sformatf("ev%0d_cyc", idx), ev_cyc[idx], ecyc);
      check_int($sformatf("ev%0d_code", idx), ev_code[idx], ecode);
      check_int($sformatf("ev%0d_multi", idx), ev_multi[idx], emulti);
    end
  endtask

  task automatic m_reset();
    for (int j = 0; j <= D + 2; j++) m_hist[j] = '0;
    m_deb = '0; m_deb_old = '0; m_trk = -1;
    m_val = 0; m_code = '0; m_multi = 0;
  endtask

  task automatic m_step(input bit [3:0] pressed);
    bit [3:0] pe;
    bit       all_diff;
    pe = m_deb & ~m_deb_old;
    m_val = 0;
    if (pe != 0) begin
      for (int i = 3; i >= 0; i--) if (pe[i]) m_trk = i;
      m_val = 1; m_code = 2'(m_trk); m_multi = $countones(m_deb) > 1;
      m_due = m_n + RD;
    end else if (m_trk >= 0) begin
      if (!m_deb[m_trk]) m_trk = -1;
      else if (m_n == m_due) begin
        m_val = 1; m_code = 2'(m_trk); m_multi = $countones(m_deb) > 1;
        m_due = m_n + RP;
      end
    end
    for (int j = D + 2; j >= 1; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = pressed;
    m_deb_old = m_deb;
    // A level is accepted once D+1 consecutive samples (seen through the
    // two-flop delay) all disagree with the current debounced state.
    for (int k = 0; k < 4; k++) begin
      all_diff = 1;
      for (int j = 2; j <= D + 2; j++) if (m_hist[j][k] == m_deb_old[k]) all_diff = 0;
      if (all_diff) m_deb[k] = ~m_deb_old[k];
    end
    m_n++;
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    s_key = keyI;
    s_rst = rstnI;
  end

  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (!rstnI) m_reset();
      else if (s_rst) m_step(~s_key);
      n_chk++;
      if ({keysO, anyO, validO, codeO, multiO} !== {m_deb, |m_deb, m_val, m_code, m_multi}) begin
        n_fail++;
        $display("FAIL outputs cyc %0d: got keys=%b any=%b valid=%b code=%0d multi=%b, expected keys=%b any=%b valid=%b code=%0d multi=%b",
                 cyc, keysO, anyO, validO, codeO, multiO, m_deb, |m_deb, m_val, m_code, m_multi);
      end
      if (validO === 1'b1) begin
        ev_cyc.push_back(cyc); ev_code.push_back(int'(codeO)); ev_multi.push_back(int'(multiO));
      end
      if (valid0 === 1'b1) n_v0++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ev_clear();
    ev_cyc.delete(); ev_code.delete(); ev_multi.delete();
  endtask

  initial begin
    rstnI = 1'b1; keyI = 4'hF; key0I = 4'hF;
    #1 rstnI = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("reset_outs", int'({keysO, anyO, validO, codeO, multiO}), 0);
    step(1);
    rstnI = 1'b1;
    step(5);

    // Single key held: event 8 edges after it is driven, then +20, +8, +8.
    ev_clear(); c0 = cyc; keyI[2] = 1'b0;
    step(50);
    check_int("hold_ev_count", ev_cyc.size(), 4);
    check_ev(0, c0 + 8, 2, 0);
    check_ev(1, c0 + 28, 2, 0);
    check_ev(2, c0 + 36, 2, 0);
    check_ev(3, c0 + 44, 2, 0);
    keyI = 4'hF; step(12);

    // Glitch shorter than the debounce window.
    ev_clear(); keyI[1] = 1'b0; step(3); keyI[1] = 1'b1; step(15);
    check_int("glitch_ev_count", ev_cyc.size(), 0);
    check_int("glitch_keys", int'(keysO), 0);

    // Simultaneous press of keys 3 and 0, then release of the tracked key.
    ev_clear(); c0 = cyc; keyI = 4'b0110;
    step(10);
    check_ev(0, c0 + 8, 0, 1);
    keyI[0] = 1'b1; step(40);
    check_int("simul_ev_count", ev_cyc.size(), 1);
    check_int("simul_keys", int'(keysO), 8);
    keyI = 4'hF; step(12);

    // Key 1 repeating, key 2 preempts.
    ev_clear(); c0 = cyc; keyI[1] = 1'b0;
    step(30); keyI[2] = 1'b0;
    step(30);
    check_int("preempt_ev_count", ev_cyc.size(), 5);
    check_ev(0, c0 + 8, 1, 0);
    check_ev(1, c0 + 28, 1, 0);
    check_ev(2, c0 + 36, 1, 0);
    check_ev(3, c0 + 38, 2, 1);
    check_ev(4, c0 + 58, 2, 1);
    keyI = 4'hF; step(12);

    // Reset in the middle of repeating with the key still held.
    keyI[0] = 1'b0; step(30);
    rstnI = 1'b0;
    @(negedge clk);
    check_int("midreset_outs", int'({keysO, anyO, validO, codeO, multiO}), 0);
    ev_clear();
    step(2); rstnI = 1'b1; c1 = cyc;
    step(12);
    check_int("postreset_ev_count", ev_cyc.size(), 1);
    check_ev(0, c1 + 8, 0, 0);
    keyI = 4'hF; step(12);

    // Repeat disabled: one event for a long hold.
    n_v0 = 0; key0I[0] = 1'b0; step(100);
    check_int("norepeat_ev_count", n_v0, 1);
    check_int("norepeat_code", int'(code0), 0);
    check_int("norepeat_keys", int'(keys0), 1);
    key0I = 4'hF;

    // Random traffic: glitches, long holds, overlaps, occasional resets.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        rstnI = 1'b0; step(int'($urandom_range(1, 2))); rstnI = 1'b1;
      end else begin
        automatic int k = int'($urandom_range(0, 3));
        keyI[k] = ~keyI[k];
        if ($urandom_range(0, 2) == 0) step(int'($urandom_range(1, 5)));
        else step(int'($urandom_range(1, 40)));
      end
    end
    keyI = 4'hF; step(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
